// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the multi-channel reference-clock divider
package clk_div_pkg;

  localparam int RATIO_WD_DEF = 8;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  // Cycles spent in the requested half-period; an odd ratio gives low the extra cycle.
  function automatic logic [31:0] half_len(input logic [31:0] r, input phase_e ph);
    logic [31:0] hi;
    hi = r >> 1;
    return (ph == PH_LOW) ? (r - hi) : hi;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: low/high phase machine with boundary-only ratio updates
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int RATIO_WD = RATIO_WD_DEF
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                clk_en,
  input  logic [RATIO_WD-1:0] div_ratio,
  output logic                div_clk,
  output logic                tick,
  output logic                ratio_pend
);

  logic [RATIO_WD-1:0] act_ratio;
  logic [RATIO_WD-1:0] act_ratio_nxt;
  logic [RATIO_WD-1:0] cnt;
  logic [RATIO_WD-1:0] cnt_nxt;
  logic [RATIO_WD-1:0] len_m1;
  phase_e              phase;
  phase_e              phase_nxt;
  logic                div_reg;
  logic                div_nxt;
  logic                tick_reg;
  logic                tick_nxt;
  logic                div_mode;

  assign div_mode = clk_en && (act_ratio >= RATIO_WD'(2));
  assign len_m1   = RATIO_WD'(half_len(32'(act_ratio), phase) - 32'd1);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_ratio <= '0;
      cnt       <= '0;
      phase     <= PH_LOW;
      div_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      act_ratio <= act_ratio_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      div_reg   <= div_nxt;
      tick_reg  <= tick_nxt;
    end
  end

  always_comb begin
    act_ratio_nxt = act_ratio;
    cnt_nxt       = cnt;
    phase_nxt     = phase;
    div_nxt       = div_reg;
    tick_nxt      = 1'b0;
    if (!div_mode) begin
      // Bypass keeps the next divide period aligned to a fresh LOW start.
      act_ratio_nxt = div_ratio;
      cnt_nxt       = '0;
      phase_nxt     = PH_LOW;
      div_nxt       = 1'b0;
    end else if (cnt != len_m1) begin
      cnt_nxt = cnt + RATIO_WD'(1);
    end else begin
      cnt_nxt = '0;
      case (phase)
        PH_LOW: begin
          phase_nxt = PH_HIGH;
          div_nxt   = 1'b1;
          tick_nxt  = 1'b1;
        end
        default: begin
          // End of high phase is the only point a new ratio may take over.
          phase_nxt     = PH_LOW;
          div_nxt       = 1'b0;
          act_ratio_nxt = div_ratio;
        end
      endcase
    end
  end

  assign div_clk    = div_mode ? div_reg : i_ref_clk;
  assign tick       = div_mode ? tick_reg : (clk_en & i_rst_n);
  assign ratio_pend = div_mode && (div_ratio != act_ratio);

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent divided clocks from one reference clock
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int RATIO_WD = RATIO_WD_DEF,
  parameter int NUM_CH   = 2
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_CH-1:0]          i_clk_en,
  input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]          o_div_clk,
  output logic [NUM_CH-1:0]          o_tick,
  output logic [NUM_CH-1:0]          o_ratio_pend
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .RATIO_WD(RATIO_WD)
    ) u_ch (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .clk_en    (i_clk_en[k]),
      .div_ratio (i_div_ratio[k*RATIO_WD +: RATIO_WD]),
      .div_clk   (o_div_clk[k]),
      .tick      (o_tick[k]),
      .ratio_pend(o_ratio_pend[k])
    );
  end

endmodule
